// File: rtl/i2c_slave.sv
// I2C slave: 2-FF synchronised, glitch-filtered SCL/SDA, 7-bit addressing, byte read/write.
// Define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low while waiting for tx data or rx hand-off.
module i2c_slave #(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic       clk_i,
   input  logic       s_rst_n_i,
   input  logic       en_i,
   input  logic [6:0] own_addr_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic [7:0] status_o,
   input  logic       scl_i,
   output logic       scl_o,
   output logic       scl_t,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_t
);

   typedef enum logic [2:0] {
      StIdle, StAddr, StAddrAck, StRxData, StRxAck, StTxData, StTxAck, StWaitStop
   } state_e;

   // Bit 0 carries SCL, bit 1 carries SDA.
   logic [1:0] sync1_q, sync2_q, filt_q, filt_prev_q;
   logic [2:0] fcnt_q [2];

   always_ff @(posedge clk_i or negedge s_rst_n_i) begin
      if (!s_rst_n_i) begin
         sync1_q     <= 2'b11;
         sync2_q     <= 2'b11;
         filt_q      <= 2'b11;
         filt_prev_q <= 2'b11;
         fcnt_q[0]   <= '0;
         fcnt_q[1]   <= '0;
      end else begin
         sync1_q     <= {sda_i, scl_i};
         sync2_q     <= sync1_q;
         filt_prev_q <= filt_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == 3'(FILTER_LEN - 1)) begin
               filt_q[i] <= sync2_q[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + 3'd1;
            end
         end
      end
   end

   logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
   assign scl_f     = filt_q[0];
   assign sda_f     = filt_q[1];
   assign scl_rise  = scl_f & ~filt_prev_q[0];
   assign scl_fall  = ~scl_f & filt_prev_q[0];
   assign start_det = scl_f & filt_prev_q[0] & filt_prev_q[1] & ~sda_f;
   assign stop_det  = scl_f & filt_prev_q[0] & ~filt_prev_q[1] & sda_f;

   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       byte_done_q, byte_done_d;
   logic [7:0] rx_sh_q, rx_sh_d;
   logic [6:0] tx_sh_q, tx_sh_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
   logic       sda_t_q, sda_t_d;
   logic       busy_q, busy_d, addressed_q, addressed_d, dir_q, dir_d, nack_q, nack_d;
   logic       ack_bit_q, ack_bit_d, armed_q, armed_d;
   logic [6:0] own_addr_q, own_addr_d;
   logic       load_tx;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
   logic       stretch_q, stretch_d, tx_pend_q, tx_pend_d;
`endif

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      byte_done_d = byte_done_q;
      rx_sh_d     = rx_sh_q;
      tx_sh_d     = tx_sh_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_ready_d  = 1'b0;
      sda_t_d     = sda_t_q;
      busy_d      = busy_q;
      addressed_d = addressed_q;
      dir_d       = dir_q;
      nack_d      = nack_q;
      ack_bit_d   = ack_bit_q;
      armed_d     = armed_q;
      own_addr_d  = own_addr_q;
      load_tx     = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch_d   = stretch_q;
      tx_pend_d   = tx_pend_q;
`endif
      if (!en_i) begin
         state_d     = StIdle;
         sda_t_d     = 1'b1;
         busy_d      = 1'b0;
         addressed_d = 1'b0;
         byte_done_d = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
         stretch_d   = 1'b0;
         tx_pend_d   = 1'b0;
`endif
      end else if (stop_det) begin
         // Status describes the current transaction only, so STOP clears all of it.
         armed_d     = 1'b1;
         state_d     = StIdle;
         sda_t_d     = 1'b1;
         busy_d      = 1'b0;
         addressed_d = 1'b0;
         dir_d       = 1'b0;
         nack_d      = 1'b0;
         byte_done_d = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
         stretch_d   = 1'b0;
         tx_pend_d   = 1'b0;
`endif
      end else if (start_det) begin
         armed_d     = 1'b1;
         state_d     = StAddr;
         bit_cnt_d   = 3'd0;
         byte_done_d = 1'b0;
         sda_t_d     = 1'b1;
         busy_d      = 1'b1;
         addressed_d = 1'b0;
         dir_d       = 1'b0;
         nack_d      = 1'b0;
         own_addr_d  = own_addr_i;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
         stretch_d   = 1'b0;
         tx_pend_d   = 1'b0;
`endif
      end else if (armed_q) begin
         case (state_q)
            StAddr, StRxData: begin
               if (scl_rise) begin
                  rx_sh_d   = {rx_sh_q[6:0], sda_f};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
               end else if (scl_fall && byte_done_q) begin
                  byte_done_d = 1'b0;
                  if (state_q == StAddr) begin
                     // General call (0x00) is never acknowledged.
                     if (rx_sh_q[7:1] == own_addr_q && rx_sh_q[7:1] != 7'h00) begin
                        state_d     = StAddrAck;
                        sda_t_d     = 1'b0;
                        addressed_d = 1'b1;
                        dir_d       = rx_sh_q[0];
                     end else begin
                        state_d = StWaitStop;
                     end
                  end else begin
                     state_d    = StRxAck;
                     sda_t_d    = 1'b0;
                     rx_data_d  = rx_sh_q;
                     rx_valid_d = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                     stretch_d  = 1'b1;
`endif
                  end
               end
            end
            StAddrAck: begin
               if (scl_fall) begin
                  if (dir_q) begin
                     state_d = StTxData;
                     load_tx = 1'b1;
                  end else begin
                     state_d = StRxData;
                     sda_t_d = 1'b1;
                  end
               end
            end
            StRxAck: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
               if (stretch_q && rx_valid_q) stretch_d = 1'b0;
`endif
               if (scl_fall) begin
                  state_d = StRxData;
                  sda_t_d = 1'b1;
               end
            end
            StTxData: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
               if (tx_pend_q && tx_valid_i) load_tx = 1'b1;
`endif
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
               end else if (scl_fall) begin
                  if (byte_done_q) begin
                     byte_done_d = 1'b0;
                     state_d     = StTxAck;
                     sda_t_d     = 1'b1;
                  end else begin
                     sda_t_d = tx_sh_q[6];
                     tx_sh_d = {tx_sh_q[5:0], 1'b1};
                  end
               end
            end
            StTxAck: begin
               if (scl_rise) begin
                  ack_bit_d = sda_f;
               end else if (scl_fall) begin
                  if (ack_bit_q) begin
                     nack_d  = 1'b1;
                     state_d = StWaitStop;
                  end else begin
                     state_d = StTxData;
                     load_tx = 1'b1;
                  end
               end
            end
            StIdle, StWaitStop: ;
            default: state_d = StIdle;
         endcase
      end

      // MSB goes straight onto SDA; tx_sh holds the remaining seven bits.
      if (load_tx) begin
         if (tx_valid_i) begin
            tx_sh_d    = tx_data_i[6:0];
            sda_t_d    = tx_data_i[7];
            tx_ready_d = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            tx_pend_d  = 1'b0;
            stretch_d  = 1'b0;
`endif
         end else begin
            sda_t_d = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            tx_pend_d = 1'b1;
            stretch_d = 1'b1;
`else
            tx_sh_d = 7'h7F;
`endif
         end
      end
   end

   always_ff @(posedge clk_i or negedge s_rst_n_i) begin
      if (!s_rst_n_i) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         byte_done_q <= 1'b0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_ready_q  <= 1'b0;
         sda_t_q     <= 1'b1;
         busy_q      <= 1'b0;
         addressed_q <= 1'b0;
         dir_q       <= 1'b0;
         nack_q      <= 1'b0;
         ack_bit_q   <= 1'b1;
         armed_q     <= 1'b0;
         own_addr_q  <= '0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
         stretch_q   <= 1'b0;
         tx_pend_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_done_q <= byte_done_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_ready_q  <= tx_ready_d;
         sda_t_q     <= sda_t_d;
         busy_q      <= busy_d;
         addressed_q <= addressed_d;
         dir_q       <= dir_d;
         nack_q      <= nack_d;
         ack_bit_q   <= ack_bit_d;
         armed_q     <= armed_d;
         own_addr_q  <= own_addr_d;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
         stretch_q   <= stretch_d;
         tx_pend_q   <= tx_pend_d;
`endif
      end
   end

   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign tx_ready_o = tx_ready_q;
   assign sda_o      = 1'b0;
   assign scl_o      = 1'b0;
   assign sda_t      = sda_t_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
   assign scl_t    = ~stretch_q;
   assign status_o = {3'b000, stretch_q, nack_q, dir_q, addressed_q, busy_q};
`else
   assign scl_t    = 1'b1;
   assign status_o = {3'b000, 1'b0, nack_q, dir_q, addressed_q, busy_q};
`endif

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master with wired-AND SCL/SDA lines.
`timescale 1ns/1ps
module tb_i2c_slave;
   localparam int Q = 10;  // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n, en, tx_valid, tx_ready, rx_valid;
   logic [6:0] own_addr;
   logic [7:0] tx_data, rx_data, status;
   logic       scl_o, scl_t, sda_o, sda_t, scl_m, sda_m, scl_bus, sda_bus;
   int         n_cmp = 0, n_err = 0, rx_cnt = 0, tx_cnt = 0, stretch_cnt = 0, busy_seen = 0;
   logic [7:0] rx_last = 8'h00;

   always #5 clk = ~clk;

   assign scl_bus = scl_m & (scl_t | scl_o);
   assign sda_bus = sda_m & (sda_t | sda_o);

   i2c_slave #(.FILTER_LEN(3)) dut (
      .clk_i      (clk),
      .s_rst_n_i  (rst_n),
      .en_i       (en),
      .own_addr_i (own_addr),
      .tx_data_i  (tx_data),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .status_o   (status),
      .scl_i      (scl_bus),
      .scl_o      (scl_o),
      .scl_t      (scl_t),
      .sda_i      (sda_bus),
      .sda_o      (sda_o),
      .sda_t      (sda_t)
   );

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt  = rx_cnt + 1;
         rx_last = rx_data;
      end
      if (tx_ready) tx_cnt = tx_cnt + 1;
      if (!scl_t) stretch_cnt = stretch_cnt + 1;
      if (status[0]) busy_seen = 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scl_high();
      int n = 0;
      scl_m = 1'b1;
      while (scl_bus !== 1'b1 && n < 2000) begin
         wait_clk(1);
         n++;
      end
      if (scl_bus !== 1'b1) check("scl_release", {31'd0, scl_bus}, 32'd1);
   endtask

   task automatic bus_start();
      if (scl_m == 1'b0) begin
         sda_m = 1'b1; wait_clk(Q);
         scl_high();   wait_clk(Q);
      end
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_clk(Q);
      scl_high();   wait_clk(Q);
      sda_m = 1'b1; wait_clk(2 * Q);
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      sda_m = b; wait_clk(Q);
      scl_high(); wait_clk(Q);
      r = sda_bus; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
      bit_xfer(1'b1, ack);
   endtask

   task automatic read_byte(input logic ack_in, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         d[i] = r;
      end
      bit_xfer(ack_in, r);
   endtask

   initial begin
      logic       ack, r;
      logic [7:0] d;
      logic [7:0] addr_w;
      addr_w = 8'hA0;
      rst_n = 1'b0; en = 1'b1; own_addr = 7'h50; tx_data = 8'h00; tx_valid = 1'b0;
      scl_m = 1'b1; sda_m = 1'b1;
      wait_clk(3);
      check("rst_status", status, 8'h00);
      check("rst_sda_t", sda_t, 1);
      check("rst_scl_t", scl_t, 1);
      check("rst_lines_o", {scl_o, sda_o}, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_strobes", {rx_valid, tx_ready}, 0);
      rst_n = 1'b1;
      wait_clk(10);

      // Write 0x3C to 0x50
      bus_start();
      send_byte(8'hA0, ack); check("w_addr_ack", ack, 0);
      check("w_status", status, 8'h03);
      send_byte(8'h3C, ack); check("w_data_ack", ack, 0);
      bus_stop();
      check("w_rx_count", rx_cnt, 1);
      check("w_rx_data", rx_last, 8'h3C);
      check("w_status_end", status, 8'h00);

      // Read 0x5A, master NACKs
      tx_data = 8'h5A; tx_valid = 1'b1; tx_cnt = 0;
      bus_start();
      send_byte(8'hA1, ack); check("r_addr_ack", ack, 0);
      check("r_status", status, 8'h07);
      read_byte(1'b1, d);
      check("r_data", d, 8'h5A);
      check("r_tx_ready", tx_cnt, 1);
      check("r_status_nack", status, 8'h0F);
      check("r_sda_released", sda_t, 1);
      bus_stop();
      check("r_status_end", status, 8'h00);

`ifndef I2C_SLAVE_CLK_STRETCH_EN
      // No tx data: 0xFF is returned and nothing is accepted
      tx_valid = 1'b0; tx_cnt = 0;
      bus_start();
      send_byte(8'hA1, ack); check("ff_addr_ack", ack, 0);
      read_byte(1'b1, d);
      check("ff_data", d, 8'hFF);
      check("ff_tx_ready", tx_cnt, 0);
      bus_stop();
`endif

      // Wrong address and general call are not acknowledged
      bus_start();
      send_byte(8'hA2, ack); check("wrong_addr_nack", ack, 1);
      check("wrong_addr_status", status, 8'h01);
      bus_stop();
      own_addr = 7'h00;
      bus_start();
      send_byte(8'h00, ack); check("gcall_nack", ack, 1);
      bus_stop();
      own_addr = 7'h50;

      // SDA glitches while idle: 2 clk rejected, 3 clk accepted as START
      busy_seen = 0;
      sda_m = 1'b0; wait_clk(2); sda_m = 1'b1; wait_clk(20);
      check("glitch2_no_start", busy_seen, 0);
      sda_m = 1'b0; wait_clk(3); sda_m = 1'b1; wait_clk(20);
      check("glitch3_start", busy_seen, 1);
      check("glitch3_status", status, 8'h00);

      // Write 0x11, repeated START, read two bytes
      rx_cnt = 0; tx_cnt = 0;
      bus_start();
      send_byte(8'hA0, ack); check("rs_addr_ack", ack, 0);
      send_byte(8'h11, ack); check("rs_data_ack", ack, 0);
      check("rs_rx_data", rx_last, 8'h11);
      tx_data = 8'hC3; tx_valid = 1'b1;
      bus_start();
      send_byte(8'hA1, ack); check("rs_raddr_ack", ack, 0);
      check("rs_dir", status, 8'h07);
      tx_data = 8'h96;
      read_byte(1'b0, d); check("rs_byte0", d, 8'hC3);
      read_byte(1'b1, d); check("rs_byte1", d, 8'h96);
      check("rs_tx_ready", tx_cnt, 2);
      check("rs_rx_count", rx_cnt, 1);
      bus_stop();

      // en_i drop while the address ACK is driven
      bus_start();
      for (int i = 7; i >= 0; i--) bit_xfer(addr_w[i], r);
      check("en_ack_driven", sda_t, 0);
      en = 1'b0; wait_clk(1);
      check("en_sda_released", sda_t, 1);
      check("en_status", status, 8'h00);
      en = 1'b1;
      bus_stop();

      // Reset while the address ACK is driven, then a normal transfer
      bus_start();
      for (int i = 7; i >= 0; i--) bit_xfer(addr_w[i], r);
      check("rst_ack_driven", sda_t, 0);
      rst_n = 1'b0; #1;
      check("rst_async_sda_t", sda_t, 1);
      check("rst_async_status", status, 8'h00);
      check("rst_async_rx_data", rx_data, 8'h00);
      wait_clk(3); rst_n = 1'b1; wait_clk(3);
      bus_stop();
      rx_cnt = 0;
      bus_start();
      send_byte(8'hA0, ack); check("post_rst_ack", ack, 0);
      send_byte(8'h77, ack);
      bus_stop();
      check("post_rst_rx", rx_last, 8'h77);
      check("post_rst_rx_count", rx_cnt, 1);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
      // tx data arrives 50 clk late: SCL is held low meanwhile
      tx_valid = 1'b0; tx_data = 8'h5A;
      bus_start();
      send_byte(8'hA1, ack); check("st_addr_ack", ack, 0);
      stretch_cnt = 0;
      check("st_status", status, 8'h17);
      wait_clk(50); tx_valid = 1'b1;
      read_byte(1'b1, d);
      check("st_data", d, 8'h5A);
      check("st_len", {31'd0, (stretch_cnt >= 50 && stretch_cnt <= 56)}, 32'd1);
      bus_stop();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 3, setting the number of consecutive equal synchronized samples needed to accept a new SCL/SDA level (1..8).
REQ-002 The block SHALL have port clk_i, input, 1, the single system clock; all flops are clocked on its rising edge.
REQ-003 The block SHALL have port s_rst_n_i, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port en_i, input, 1; while low, bus events are ignored and SDA/SCL are released.
REQ-005 The block SHALL have port own_addr_i, input, 7, the 7-bit slave address; it is sampled at each START.
REQ-006 The block SHALL have port tx_data_i, input, 8, the byte to return on a master read.
REQ-007 The block SHALL have port tx_valid_i, input, 1, which qualifies tx_data_i.
REQ-008 The block SHALL have port tx_ready_o, output, 1, which accepts tx_data_i for one cycle.
REQ-009 The block SHALL have port rx_data_o, output, 8, the last byte written by the master.
REQ-010 The block SHALL have port rx_valid_o, output, 1, a one-cycle strobe marking rx_data_o new.
REQ-011 The block SHALL have port status_o, output, 8: |r|r|r|stretching|nack_rcvd|dir|addressed|busy|.
REQ-012 The block SHALL have ports scl_i, input, 1; scl_o, output, 1; and scl_t, output, 1 (1 = released).
REQ-013 The block SHALL have ports sda_i, input, 1; sda_o, output, 1; and sda_t, output, 1 (1 = released).

Function
REQ-014 scl_i and sda_i SHALL pass through 2-FF synchronizers, then a FILTER_LEN glitch filter; all detection uses the filtered levels.
REQ-015 START SHALL be detected as filtered SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1.
REQ-016 START or repeated START SHALL move the FSM to ADDR from any state and clear the bit counter.
REQ-017 STOP SHALL move the FSM to IDLE from any state.
REQ-018 FSM states SHALL be exactly: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
REQ-019 Data SHALL be sampled MSB first on the filtered SCL rising edge; SDA SHALL be driven/changed on the clk cycle after the filtered SCL falling edge.
REQ-020 ADDR: after 8 bits (7 address + R/W), a match SHALL go to ADDR_ACK and drive ACK (sda_o=0, sda_t=0) for one SCL period; a mismatch SHALL go to WAIT_STOP with SDA released.
REQ-021 Write path (R/W=0): RX_DATA shifts 8 bits, then RX_ACK drives ACK; rx_valid_o SHALL pulse with rx_data_o on the falling SCL edge that begins RX_ACK.
REQ-022 Read path (R/W=1): on entering TX_DATA, if tx_valid_i=1 the block SHALL load tx_data_i and pulse tx_ready_o once.
REQ-023 In TX_DATA, if tx_valid_i=0 (macro absent), the block SHALL send 0xFF.
REQ-024 TX_ACK SHALL release SDA and sample the master ACK; ACK (0) SHALL return to TX_DATA, NACK (1) SHALL set nack_rcvd and go to WAIT_STOP.
REQ-025 A bit counter of 3 bits SHALL wrap 7->0 at each byte boundary.
REQ-026 Address 0x00 (general call) SHALL NOT be acknowledged.
REQ-027 sda_o SHALL be constant 0; the line is controlled via sda_t only, and likewise scl_o=0 with scl_t.
REQ-028 en_i deassertion mid-transfer SHALL go to IDLE within one cycle and release both lines.
REQ-029 START and STOP within the same filtered sample are impossible; if both are flagged, STOP SHALL win.
REQ-030 busy SHALL be set from START to STOP; addressed SHALL be set from address match to STOP or repeated START; dir SHALL hold the latched R/W.

Reset
REQ-031 On s_rst_n_i=0, the FSM SHALL enter IDLE, the synchronizers and filters SHALL be set to 1, and outputs SHALL be: sda_t=1, scl_t=1, sda_o=0, scl_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0x00, status_o=0x00.
REQ-032 After reset release, the block SHALL ignore the bus until the first STOP or START seen with en_i=1.

Configuration
REQ-033 With macro I2C_SLAVE_CLK_STRETCH_EN defined, the block SHALL hold SCL low (scl_t=0) after the SCL falling edge in two cases, setting stretching=1 while doing so: entering TX_DATA with tx_valid_i=0, until tx_valid_i=1; and entering RX_ACK, until one cycle after rx_valid_o.
REQ-034 Without I2C_SLAVE_CLK_STRETCH_EN, scl_t SHALL be constant 1, stretching SHALL be constant 0, and REQ-023 SHALL apply.

Verification
REQ-035 own_addr=0x50, master writes 0xA0 then 0x3C, then STOP -> address ACKed, one rx_valid_o pulse with rx_data_o=0x3C, status_o returns to 0x00.
REQ-036 Master sends 0xA1, tx_data_i=0x5A valid, master NACKs -> SDA shows 0x5A MSB first, tx_ready_o pulses once, nack_rcvd=1, FSM in WAIT_STOP.
REQ-037 Master addresses 0x51 -> no ACK (SDA released in the 9th bit); a 2-clk SDA glitch with FILTER_LEN=3 -> no START detected.
REQ-038 Write 0xA0 then 0x11, repeated START, then 0xA1 -> rx 0x11 then the read phase; dir=1.
REQ-039 Reset asserted mid-byte -> outputs at reset values on the same clock edge; the next START is handled normally.
REQ-040 With I2C_SLAVE_CLK_STRETCH_EN, read with tx_valid_i delayed 50 clk -> SCL held low for 50 clk, then 0x5A is sent.
